// File: rtl/oven_pkg.sv
// rtl/oven_pkg.sv - shared state encoding and constants for the oven controller
// Contents: state_t FSM encoding, display blank code, bake-time wrap point,
// temperature/seconds datapath widths.
package oven_pkg;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_IDLE    = 3'd1,
    S_PREHEAT = 3'd2,
    S_BAKE    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int TEMP_W = 11;
  localparam int SECS_W = 12;

  localparam logic [3:0]        BLANK     = 4'hF;
  localparam logic [SECS_W-1:0] TIME_WRAP = 12'd3540;
  localparam logic [SECS_W-1:0] TIME_INC  = 12'd60;

endpackage

// File: rtl/oven_bin2bcd.sv
// rtl/oven_bin2bcd.sv - combinational binary to 4-digit BCD (double-dabble)
// Ports:
//   i_bin  in  W   unsigned binary value (must be <= 9999)
//   o_bcd  out 16  four BCD digits, thousands in [15:12]
module oven_bin2bcd #(
  parameter int W = 12
) (
  input  logic [W-1:0] i_bin,
  output logic [15:0]  o_bcd
);

  logic [W+15:0] w_sh;

  always_comb begin
    w_sh = {16'd0, i_bin};
    for (int i = 0; i < W; i++) begin
      // Add-3 on any digit >= 5 so the following shift carries correctly into the next digit.
      for (int d = 0; d < 4; d++) begin
        if (w_sh[W+4*d +: 4] >= 4'd5) begin
          w_sh[W+4*d +: 4] = w_sh[W+4*d +: 4] + 4'd3;
        end
      end
      w_sh = w_sh << 1;
    end
    o_bcd = w_sh[W +: 16];
  end

endmodule

// File: rtl/oven_ctrl.sv
// rtl/oven_ctrl.sv - oven state machine, 1 Hz tick, chamber model and BCD display drive
// Optional feature macro: OVEN_DOOR_EN (adds door_open input; door open pauses heating/countdown).
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   door_open                          (OVEN_DOOR_EN only) 1 = door open
//   power                              level, 1 = oven on
//   temp_up, temp_dn, start, time_set  level buttons, rising edge = press
//   heater_on, buzzer                  heating element / bake-finished alarm
//   state                              FSM state encoding (state_t)
//   cur_temp, target_temp              chamber temperature / setpoint (degF)
//   bake_secs                          remaining bake seconds 0..3540
//   d3, d2, d1, d0                     BCD display digits, 4'hF = blank
module oven_ctrl
  import oven_pkg::*;
#(
  parameter int TICK_DIV     = 50000000,
  parameter int TEMP_MIN     = 150,
  parameter int TEMP_MAX     = 550,
  parameter int TEMP_STEP    = 25,
  parameter int TEMP_DEFAULT = 350,
  parameter int AMBIENT      = 70,
  parameter int RAMP_STEP    = 10,
  parameter int COOL_STEP    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef OVEN_DOOR_EN
  input  logic              door_open,
`endif
  input  logic              power,
  input  logic              temp_up,
  input  logic              temp_dn,
  input  logic              start,
  input  logic              time_set,
  output logic              heater_on,
  output logic              buzzer,
  output logic [2:0]        state,
  output logic [TEMP_W-1:0] cur_temp,
  output logic [TEMP_W-1:0] target_temp,
  output logic [SECS_W-1:0] bake_secs,
  output logic [3:0]        d3,
  output logic [3:0]        d2,
  output logic [3:0]        d1,
  output logic [3:0]        d0
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TEMP_W-1:0] L_MIN  = TEMP_W'(TEMP_MIN);
  localparam logic [TEMP_W-1:0] L_MAX  = TEMP_W'(TEMP_MAX);
  localparam logic [TEMP_W-1:0] L_STEP = TEMP_W'(TEMP_STEP);
  localparam logic [TEMP_W-1:0] L_DEF  = TEMP_W'(TEMP_DEFAULT);
  localparam logic [TEMP_W-1:0] L_AMB  = TEMP_W'(AMBIENT);
  localparam logic [TEMP_W-1:0] L_RAMP = TEMP_W'(RAMP_STEP);
  localparam logic [TEMP_W-1:0] L_COOL = TEMP_W'(COOL_STEP);

  logic [CW-1:0]     r_tick_cnt;
  logic              w_tick;
  logic              r_prev_up, r_prev_dn, r_prev_st, r_prev_ts;
  logic              w_up_p, w_dn_p, w_st_p, w_ts_p;
  logic              w_door;
  state_t            r_state;
  logic [TEMP_W-1:0] r_cur_temp, r_target_temp;
  logic [SECS_W-1:0] r_bake_secs;
  logic              r_heater, r_buzzer;
  logic [3:0]        r_d3, r_d2, r_d1, r_d0;
  logic [TEMP_W-1:0] w_disp_temp;
  logic [SECS_W-1:0] w_mins, w_secs;
  logic [12:0]       w_mmss;
  logic [15:0]       w_temp_bcd, w_time_bcd;

`ifdef OVEN_DOOR_EN
  assign w_door = door_open;
`else
  assign w_door = 1'b0;
`endif

  assign w_tick = (r_tick_cnt == CW'(TICK_DIV - 1));
  assign w_up_p = temp_up  & ~r_prev_up;
  assign w_dn_p = temp_dn  & ~r_prev_dn;
  assign w_st_p = start    & ~r_prev_st;
  assign w_ts_p = time_set & ~r_prev_ts;

  // Cooling and ramping saturate before the subtract/add so values never wrap.
  function automatic logic [TEMP_W-1:0] f_cool(input logic [TEMP_W-1:0] t);
    if (t >= L_AMB + L_COOL) return t - L_COOL;
    return L_AMB;
  endfunction

  function automatic logic [TEMP_W-1:0] f_ramp(input logic [TEMP_W-1:0] t,
                                               input logic [TEMP_W-1:0] tgt);
    if (t >= tgt) return tgt;
    if (tgt - t <= L_RAMP) return tgt;
    return t + L_RAMP;
  endfunction

  // Display sources: temperature (setpoint in IDLE) and MM:SS packed as MM*100+SS.
  assign w_disp_temp = (r_state == S_IDLE) ? r_target_temp : r_cur_temp;
  assign w_mins      = r_bake_secs / TIME_INC;
  assign w_secs      = r_bake_secs % TIME_INC;
  assign w_mmss      = 13'(w_mins) * 13'd100 + 13'(w_secs);

  oven_bin2bcd u_temp_bcd (
    .i_bin ({1'b0, w_disp_temp}),
    .o_bcd (w_temp_bcd)
  );

  oven_bin2bcd #(.W(13)) u_time_bcd (
    .i_bin (w_mmss),
    .o_bcd (w_time_bcd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_cnt    <= '0;
      r_prev_up     <= 1'b1;
      r_prev_dn     <= 1'b1;
      r_prev_st     <= 1'b1;
      r_prev_ts     <= 1'b1;
      r_state       <= S_OFF;
      r_cur_temp    <= L_AMB;
      r_target_temp <= L_DEF;
      r_bake_secs   <= '0;
      r_heater      <= 1'b0;
      r_buzzer      <= 1'b0;
      r_d3          <= BLANK;
      r_d2          <= BLANK;
      r_d1          <= BLANK;
      r_d0          <= BLANK;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CW'(1);
      r_prev_up  <= temp_up;
      r_prev_dn  <= temp_dn;
      r_prev_st  <= start;
      r_prev_ts  <= time_set;

      if (r_state == S_BAKE || r_state == S_DONE) begin
        {r_d3, r_d2, r_d1, r_d0} <= w_time_bcd;
      end else begin
        // Temperatures stay below 1000, so the thousands digit is always blanked.
        r_d3 <= (w_temp_bcd[15:12] == 4'd0) ? BLANK : w_temp_bcd[15:12];
        {r_d2, r_d1, r_d0} <= w_temp_bcd[11:0];
      end

      if (!power) begin
        r_state  <= S_OFF;
        r_heater <= 1'b0;
        r_buzzer <= 1'b0;
        if (w_tick) r_cur_temp <= f_cool(r_cur_temp);
      end else begin
        case (r_state)
          S_OFF: begin
            if (w_tick) r_cur_temp <= f_cool(r_cur_temp);
            r_state <= S_IDLE;
          end
          S_IDLE: begin
            r_heater <= 1'b0;
            r_buzzer <= 1'b0;
            if (w_tick) r_cur_temp <= f_cool(r_cur_temp);
            if (w_up_p && !w_dn_p) begin
              r_target_temp <= (r_target_temp >= L_MAX - L_STEP) ? L_MAX : r_target_temp + L_STEP;
            end else if (w_dn_p && !w_up_p) begin
              r_target_temp <= (r_target_temp <= L_MIN + L_STEP) ? L_MIN : r_target_temp - L_STEP;
            end
            if (w_ts_p) begin
              r_bake_secs <= (r_bake_secs >= TIME_WRAP) ? '0 : r_bake_secs + TIME_INC;
            end
            // Start looks at the registered (pre-increment) bake time.
            if (w_st_p && r_bake_secs != '0) begin
              r_state  <= S_PREHEAT;
              r_heater <= 1'b1;
            end
          end
          S_PREHEAT: begin
            if (w_door) begin
              r_heater <= 1'b0;
              if (w_tick) r_cur_temp <= f_cool(r_cur_temp);
            end else if (w_st_p) begin
              r_state  <= S_IDLE;
              r_heater <= 1'b0;
            end else begin
              r_heater <= 1'b1;
              if (r_cur_temp >= r_target_temp) begin
                r_state <= S_BAKE;
              end else if (w_tick) begin
                r_cur_temp <= f_ramp(r_cur_temp, r_target_temp);
              end
            end
          end
          S_BAKE: begin
            if (w_door) begin
              r_heater <= 1'b0;
              if (w_tick) r_cur_temp <= f_cool(r_cur_temp);
            end else if (w_st_p) begin
              r_state  <= S_IDLE;
              r_heater <= 1'b0;
`ifdef OVEN_DOOR_EN
            end else if (r_cur_temp < r_target_temp) begin
              // Re-heat after the door closes; countdown resumes at setpoint.
              r_heater <= 1'b1;
              if (w_tick) r_cur_temp <= f_ramp(r_cur_temp, r_target_temp);
`endif
            end else begin
              r_heater   <= 1'b1;
              r_cur_temp <= r_target_temp;
              if (w_tick && r_bake_secs != '0) begin
                r_bake_secs <= r_bake_secs - SECS_W'(1);
                if (r_bake_secs == SECS_W'(1)) begin
                  r_state  <= S_DONE;
                  r_heater <= 1'b0;
                  r_buzzer <= 1'b1;
                end
              end
            end
          end
          S_DONE: begin
            r_heater <= 1'b0;
            r_buzzer <= 1'b1;
            if (w_tick) r_cur_temp <= f_cool(r_cur_temp);
            if (w_st_p) begin
              r_state  <= S_IDLE;
              r_buzzer <= 1'b0;
            end
          end
          default: begin
            r_state  <= S_OFF;
            r_heater <= 1'b0;
            r_buzzer <= 1'b0;
          end
        endcase
      end
    end
  end

  assign heater_on   = r_heater;
  assign buzzer      = r_buzzer;
  assign state       = r_state;
  assign cur_temp    = r_cur_temp;
  assign target_temp = r_target_temp;
  assign bake_secs   = r_bake_secs;
  assign d3          = r_d3;
  assign d2          = r_d2;
  assign d1          = r_d1;
  assign d0          = r_d0;

endmodule

// File: tb/tb_oven_ctrl.sv
// tb/tb_oven_ctrl.sv - table-driven and sequence checks for oven_ctrl with TICK_DIV=4
module tb_oven_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, power, temp_up, temp_dn, start, time_set;
  logic        heater_on, buzzer;
  logic [2:0]  state;
  logic [10:0] cur_temp, target_temp;
  logic [11:0] bake_secs;
  logic [3:0]  d3, d2, d1, d0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic pwr, up, dn, st, ts;
    int   e_state, e_target, e_bake, e_heater;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  oven_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .power(power), .temp_up(temp_up), .temp_dn(temp_dn),
    .start(start), .time_set(time_set), .heater_on(heater_on), .buzzer(buzzer),
    .state(state), .cur_temp(cur_temp), .target_temp(target_temp), .bake_secs(bake_secs),
    .d3(d3), .d2(d2), .d1(d1), .d0(d0)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_digits(input string name, input int e3, input int e2, input int e1, input int e0);
    chk({name, "_d3"}, d3, e3);
    chk({name, "_d2"}, d2, e2);
    chk({name, "_d1"}, d1, e1);
    chk({name, "_d0"}, d0, e0);
  endtask

  task automatic press_ts();
    time_set = 1'b1; cyc(); time_set = 1'b0; cyc();
  endtask

  task automatic press_start();
    start = 1'b1; cyc(); start = 1'b0; cyc();
  endtask

  initial begin
    int incs, prev, prevb, b;
    bit done;

    for (int i = 0; i < 9; i++)
      vecs[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, ((375 + 25*i) > 550) ? 550 : 375 + 25*i, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 550, 0, 0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 550, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 550, 60, 0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 550, 120, 0};
    for (int i = 13; i < NV; i++)
      vecs[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 550 - 25*(i-12), 120, 0};

    rst_n = 1'b0; power = 1'b1; temp_up = 1'b1; temp_dn = 1'b0; start = 1'b0; time_set = 1'b0;
    @(negedge clk);
    cyc(); cyc(); cyc();
    chk("rst_state", state, 0);
    chk("rst_target", target_temp, 350);
    chk("rst_cur", cur_temp, 70);
    chk("rst_bake", bake_secs, 0);
    chk("rst_heater", heater_on, 0);
    chk("rst_buzzer", buzzer, 0);
    chk_digits("rst", 15, 15, 15, 15);

    rst_n = 1'b1;
    cyc();
    chk("pwr_idle", state, 1);
    cyc();
    temp_up = 1'b0;
    cyc();
    chk("held_up_target", target_temp, 350);
    chk_digits("idle", 15, 3, 5, 0);

    for (int i = 0; i < NV; i++) begin
      power = vecs[i].pwr; temp_up = vecs[i].up; temp_dn = vecs[i].dn;
      start = vecs[i].st;  time_set = vecs[i].ts;
      cyc();
      temp_up = 1'b0; temp_dn = 1'b0; start = 1'b0; time_set = 1'b0;
      cyc();
      chk($sformatf("v%0d_state", i), state, vecs[i].e_state);
      chk($sformatf("v%0d_target", i), target_temp, vecs[i].e_target);
      chk($sformatf("v%0d_bake", i), bake_secs, vecs[i].e_bake);
      chk($sformatf("v%0d_heater", i), heater_on, vecs[i].e_heater);
    end

    // Preheat 70 -> 350 in 10-degree steps, then BAKE.
    start = 1'b1; cyc(); start = 1'b0;
    chk("pre_state", state, 2);
    chk("pre_heater", heater_on, 1);
    incs = 0; done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      prev = cur_temp;
      cyc();
      if (cur_temp != prev) begin
        incs++;
        chk("pre_ramp_step", cur_temp, prev + 10);
      end
      if (state == 3) done = 1;
    end
    chk("pre_reached_bake", done, 1);
    chk("pre_tick_count", incs, 28);
    chk("bake_cur", cur_temp, 350);
    cyc();
    chk_digits("bake", 0, 2, 0, 0);
    chk("bake_heater", heater_on, 1);

    // Countdown 120 s to DONE.
    done = 0; prevb = bake_secs;
    for (int k = 0; k < 700 && !done; k++) begin
      cyc();
      if (bake_secs != prevb) begin
        chk("bake_dec", bake_secs, prevb - 1);
        prevb = bake_secs;
      end
      if (state == 4) done = 1;
    end
    chk("done_reached", done, 1);
    chk("done_bake", bake_secs, 0);
    chk("done_buzzer", buzzer, 1);
    chk("done_heater", heater_on, 0);
    cyc();
    chk_digits("done", 0, 0, 0, 0);
    press_start();
    chk("ack_state", state, 1);
    chk("ack_buzzer", buzzer, 0);

    // Bake time wrap 3540 -> 0, then start ignored.
    for (int k = 0; k < 59; k++) press_ts();
    chk("wrap_max", bake_secs, 3540);
    press_ts();
    chk("wrap_zero", bake_secs, 0);
    press_start();
    chk("wrap_start_ignored", state, 1);

    // Power drop during BAKE.
    press_ts();
    press_start();
    chk("pd_pre_state", state, 2);
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      cyc();
      if (state == 3) done = 1;
    end
    chk("pd_reached_bake", done, 1);
    cyc(); cyc();
    b = bake_secs;
    power = 1'b0;
    cyc();
    chk("pd_state", state, 0);
    chk("pd_heater", heater_on, 0);
    chk("pd_bake_kept", bake_secs, b);
    chk("pd_target_kept", target_temp, 350);
    done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      prev = cur_temp;
      cyc();
      if (cur_temp != prev) chk("pd_cool_step", cur_temp, prev - 5);
      if (cur_temp == 70) done = 1;
    end
    chk("pd_reached_ambient", done, 1);
    for (int k = 0; k < 20; k++) cyc();
    chk("pd_ambient_hold", cur_temp, 70);
    chk_digits("off", 15, 0, 7, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
